// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache, grouped for the controller.
// Refill handshake: mem_req_o/mem_addr_o are held stable until a one-cycle mem_ack_i pulse delivers the line on mem_data_i.
interface icache_if #(
    parameter int LINE_WORDS = 4
);
    logic                    fetch_en_i;
    logic [31:0]             pc_i;
    logic                    flush_i;
    logic [31:0]             instr_o;
    logic                    stall_o;
    logic                    mem_req_o;
    logic [31:0]             mem_addr_o;
    logic                    mem_ack_i;
    logic [32*LINE_WORDS-1:0] mem_data_i;

    modport slave (
        input  fetch_en_i, pc_i, flush_i, mem_ack_i, mem_data_i,
        output instr_o, stall_o, mem_req_o, mem_addr_o
    );

    modport master (
        output fetch_en_i, pc_i, flush_i, mem_ack_i, mem_data_i,
        input  instr_o, stall_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with zero-latency hits,
// single-line refill over req/ack, and whole-cache flush (deferred while a refill is in flight).
module icache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    icache_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF       = 2 + WORD_BITS;
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_LSB   = OFF + IDX_BITS;
    localparam int TAG_BITS  = 32 - TAG_LSB;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        REQ    = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];
    logic                 flush_pend;
    logic                 mem_req;
    logic [31:0]          mem_addr;

    logic [IDX_BITS-1:0]  rd_idx;
    logic [IDX_BITS-1:0]  wr_idx;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [TAG_BITS-1:0]  wr_tag;
    logic [WORD_BITS-1:0] rd_word;
    logic [LINE_BITS-1:0] rd_line;
    logic                 hit;
    logic                 flush_now;
    logic                 stall;
    logic [31:0]          instr;
    logic                 unused_pc;

    assign rd_word   = bus.pc_i[OFF-1:2];
    assign rd_idx    = bus.pc_i[TAG_LSB-1:OFF];
    assign rd_tag    = bus.pc_i[31:TAG_LSB];
    assign wr_idx    = mem_addr[TAG_LSB-1:OFF];
    assign wr_tag    = mem_addr[31:TAG_LSB];
    assign rd_line   = data_mem[rd_idx];
    assign hit       = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign unused_pc = ^bus.pc_i[1:0];

    // A flush requested during a refill is held until the first READY cycle.
    assign flush_now = (state == READY) && (bus.flush_i || flush_pend);

    always_comb begin
        stall = 1'b0;
        instr = 32'd0;
        if (!rst_i) begin
            if (state != READY) begin
                stall = 1'b1;
            end else if (flush_now) begin
                stall = 1'b1;
            end else if (bus.fetch_en_i) begin
                if (hit) instr = rd_line[{rd_word, 5'b00000} +: 32];
                else     stall = 1'b1;
            end
        end
    end

    assign bus.stall_o    = stall;
    assign bus.instr_o    = instr;
    assign bus.mem_req_o  = mem_req;
    assign bus.mem_addr_o = mem_addr;
    assign dbg_state      = state;

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == REQ && bus.mem_ack_i) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= bus.mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= READY;
            valid      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                READY: begin
                    if (flush_now) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (bus.fetch_en_i && !hit) begin
                        mem_addr <= {bus.pc_i[31:OFF], {OFF{1'b0}}};
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush_i) flush_pend <= 1'b1;
                    if (bus.mem_ack_i) begin
                        valid[wr_idx] <= 1'b1;
                        mem_req       <= 1'b0;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.flush_i) flush_pend <= 1'b1;
                    state <= READY;
                end
                default: begin
                    state   <= READY;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, hits, conflict, flush (ready and in-flight),
// reset during refill and disabled fetch. Memory line words hold their own byte address.
module tb_icache_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         tests  = 0;
  int         failed = 0;

  icache_if #(.LINE_WORDS(4)) bus ();

  icache_ctrl #(.LINE_WORDS(4), .NUM_LINES(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'hC, base + 32'h8, base + 32'h4, base};
  endfunction

  // Miss on addr, ack k cycles after the first REQ cycle, end in READY showing the hit.
  task automatic do_miss(input logic [31:0] addr, input int k);
    bus.fetch_en_i = 1'b1;
    bus.pc_i       = addr;
    #1;
    chk("miss_stall", {31'd0, bus.stall_o}, 32'd1);
    chk("miss_instr", bus.instr_o, 32'd0);
    chk("miss_noreq", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
    for (int i = 0; i <= k; i++) begin
      chk("req_valid", {31'd0, bus.mem_req_o}, 32'd1);
      chk("req_addr", bus.mem_addr_o, addr & 32'hFFFF_FFF0);
      chk("req_stall", {31'd0, bus.stall_o}, 32'd1);
      if (i == k) begin
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = mk_line(addr & 32'hFFFF_FFF0);
      end
      tick();
      bus.mem_ack_i = 1'b0;
    end
    chk("refill_stall", {31'd0, bus.stall_o}, 32'd1);
    chk("refill_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
    chk("refetch_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("refetch_instr", bus.instr_o, addr);
  endtask

  task automatic hit_chk(input logic [31:0] addr);
    bus.pc_i = addr;
    #1;
    chk("hit_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("hit_instr", bus.instr_o, addr);
    chk("hit_noreq", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.fetch_en_i = 1'b0;
    bus.pc_i       = 32'd0;
    bus.flush_i    = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    #1;
    chk("rst_cycle_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("rst_cycle_instr", bus.instr_o, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // Disabled fetch on an uncached address never stalls or requests.
    bus.pc_i = 32'h40;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dis_stall", {31'd0, bus.stall_o}, 32'd0);
      chk("dis_instr", bus.instr_o, 32'd0);
      chk("dis_req", {31'd0, bus.mem_req_o}, 32'd0);
      tick();
    end

    // Cold miss: 5 stall cycles, 3 request cycles.
    do_miss(32'h0, 2);
    tick();
    hit_chk(32'h4);
    hit_chk(32'h8);
    hit_chk(32'hC);

    // Next line, ack in the very first REQ cycle.
    do_miss(32'h10, 0);
    tick();
    hit_chk(32'h0);

    // Conflict on index 0: 0x200 evicts 0x000, which then misses again.
    do_miss(32'h200, 1);
    tick();
    hit_chk(32'h14);
    do_miss(32'h0, 1);
    tick();

    // Flush in READY: stall that cycle despite the hit, then a miss.
    bus.pc_i    = 32'h0;
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", {31'd0, bus.stall_o}, 32'd1);
    chk("flush_instr", bus.instr_o, 32'd0);
    tick();
    bus.flush_i = 1'b0;
    do_miss(32'h0, 0);
    tick();

    // Flush during REQ: refill completes, one flush stall, line invalidated.
    bus.pc_i = 32'h20;
    #1;
    chk("fq_miss", {31'd0, bus.stall_o}, 32'd1);
    tick();
    bus.flush_i = 1'b1;
    #1;
    chk("fq_req1", {31'd0, bus.mem_req_o}, 32'd1);
    tick();
    bus.flush_i    = 1'b0;
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = mk_line(32'h20);
    #1;
    chk("fq_req2", {31'd0, bus.mem_req_o}, 32'd1);
    chk("fq_addr", bus.mem_addr_o, 32'h20);
    tick();
    bus.mem_ack_i = 1'b0;
    chk("fq_refill", {31'd0, bus.stall_o}, 32'd1);
    tick();
    chk("fq_flush_stall", {31'd0, bus.stall_o}, 32'd1);
    chk("fq_flush_instr", bus.instr_o, 32'd0);
    chk("fq_flush_state", {30'd0, dbg_state}, 32'd0);
    tick();
    do_miss(32'h20, 0);
    tick();

    // Reset while the request is outstanding; a late ack must not fill the line.
    bus.pc_i = 32'h30;
    #1;
    chk("rr_miss", {31'd0, bus.stall_o}, 32'd1);
    tick();
    chk("rr_req", {31'd0, bus.mem_req_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus.fetch_en_i = 1'b0;
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = mk_line(32'h30);
    #1;
    chk("rr_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rr_state", {30'd0, dbg_state}, 32'd0);
    chk("rr_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    chk("rr_no_req", {31'd0, bus.mem_req_o}, 32'd0);
    do_miss(32'h30, 0);
    tick();
    hit_chk(32'h34);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
